// File: rtl/countdown_unit_pkg.sv
// ---------------------------------------------------------------------------
// countdown_defs
//   Shared definitions for the countdown unit: controller state encoding and
//   the default counter width.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package countdown_defs;

    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : countdown_defs

// File: rtl/countdown_unit_if.sv
// ---------------------------------------------------------------------------
// countdown_unit_if
//   Control/status bundle between a requester and the countdown unit.
//   master : drives start, load_val, mode, pause, abort;
//            observes count, busy, tc, done, err.
//   slave  : the countdown unit side (directions mirrored).
// ---------------------------------------------------------------------------
interface countdown_unit_if
    import countdown_defs::*;
#(
    parameter int N = DEFAULT_N
);
    logic         start;
    logic [N-1:0] load_val;
    logic         mode;
    logic         pause;
    logic         abort;
    logic [N-1:0] count;
    logic         busy;
    logic         tc;
    logic         done;
    logic         err;

    modport master (
        output start, load_val, mode, pause, abort,
        input  count, busy, tc, done, err
    );

    modport slave (
        input  start, load_val, mode, pause, abort,
        output count, busy, tc, done, err
    );
endinterface : countdown_unit_if

// File: rtl/countdown_unit_decn.sv
// ---------------------------------------------------------------------------
// decN
//   Combinational N-bit decrementer; produces the decrement candidate for the
//   countdown unit's next-count mux.
//   Ports: din (N) in, dout (N) out = din - 1.
// ---------------------------------------------------------------------------
module decN #(
    parameter int N = 8
) (
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);
    assign dout = din - N'(1);
endmodule : decN

// File: rtl/countdown_unit.sv
// ---------------------------------------------------------------------------
// countdown_unit
//   Loadable N-bit down-counter with start/abort/pause control, one-shot and
//   auto-reload modes, a registered terminal-count pulse (tc) and a registered
//   illegal-load pulse (err). Used as the iteration counter for multi-cycle
//   datapath blocks.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - countdown_unit_if.slave (start/load_val/mode/pause/abort in,
//            count/busy/tc/done/err out)
// ---------------------------------------------------------------------------
module countdown_unit
    import countdown_defs::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                    clk,
    input  logic                    rst,
    countdown_unit_if.slave         bus
);

    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] reload_q, reload_d;
    logic         mode_q, mode_d;
    logic         tc_q, tc_d;
    logic         err_q, err_d;
    logic [N-1:0] count_dec;

    decN #(.N(N)) u_dec (
        .din  (count_q),
        .dout (count_dec)
    );

    // ------------------------------------------------------------------
    // Next-state / next-count logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (bus.pause) begin
                    // Hold everything; tc stays low through its default.
                end else if (count_q != N'(1)) begin
                    count_d = count_dec;
                end else if (!mode_q) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    count_d = reload_q;
                    tc_d    = 1'b1;
                end
                // start is deliberately ignored while running: no retrigger.
            end

            // IDLE and DONE share the (re)start logic; the only difference is
            // that a zero load leaves each in its own state.
            IDLE, DONE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (bus.pause) begin
                    // pause outranks start on every edge, so a start is held off.
                end else if (bus.start) begin
                    if (bus.load_val != '0) begin
                        state_d  = RUN;
                        count_d  = bus.load_val;
                        reload_d = bus.load_val;
                        mode_d   = bus.mode;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
            err_q    <= err_d;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.tc    = tc_q;
    assign bus.err   = err_q;

endmodule : countdown_unit

// File: tb/tb_countdown_unit.sv
// ---------------------------------------------------------------------------
// tb_countdown_unit
//   Self-checking bench for countdown_unit (N = 8). Each scenario task pushes
//   the expected post-edge outputs into a scoreboard queue as it drives the
//   stimulus, then pops and compares once the edge has happened.
// ---------------------------------------------------------------------------
module tb_countdown_unit;
    import countdown_defs::*;

    typedef struct packed {
        logic [7:0] count;
        logic       busy;
        logic       tc;
        logic       done;
        logic       err;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests  = 0;
    int   n_failed = 0;
    obs_t exp_q[$];

    countdown_unit_if #(.N(8)) bus ();

    countdown_unit #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [7:0] c, input logic b, input logic t,
                                input logic d, input logic e);
        obs_t o;
        o.count = c; o.busy = b; o.tc = t; o.done = d; o.err = e;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(bus.count, bus.busy, bus.tc, bus.done, bus.err);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("count=%0d busy=%b tc=%b done=%b err=%b",
                         o.count, o.busy, o.tc, o.done, o.err);
    endfunction

    // Drive one cycle of inputs away from the active edge, then settle past it.
    task automatic tick(input logic s, input logic [7:0] lv, input logic m,
                        input logic p, input logic a);
        @(negedge clk);
        bus.start    = s;
        bus.load_val = lv;
        bus.mode     = m;
        bus.pause    = p;
        bus.abort    = a;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        obs_t got, exp;
        // Reset state, before any clock edge.
        exp_q.push_back(mk(8'd0, 0, 0, 0, 0));
        #1;
        exp = exp_q.pop_front(); got = sample(); n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL reset_initial: got %s, expected %s", fmt(got), fmt(exp));
        end
        @(negedge clk);
        rst = 1'b0;
        // One-shot load of 8, run down to 5.
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk(8'(8 - k), 1, 0, 0, 0));
            tick(k == 0, 8'd8, 1'b0, 1'b0, 1'b0);
            exp = exp_q.pop_front(); got = sample(); n_tests++;
            if (got !== exp) begin
                n_failed++;
                $display("FAIL reset_run[%0d]: got %s, expected %s", k, fmt(got), fmt(exp));
            end
        end
        // Asynchronous reset mid-cycle with count = 5, then one idle edge.
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk(8'd0, 0, 0, 0, 0));
            if (k == 0) begin
                #2 rst = 1'b1;
                #1;
            end else begin
                @(negedge clk);
                rst = 1'b0;
                tick(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
            end
            exp = exp_q.pop_front(); got = sample(); n_tests++;
            if (got !== exp) begin
                n_failed++;
                $display("FAIL reset_async[%0d]: got %s, expected %s", k, fmt(got), fmt(exp));
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_oneshot();
        obs_t got, exp;
        for (int k = 0; k < 7; k++) begin
            if (k < 4)       exp_q.push_back(mk(8'(4 - k), 1, 0, 0, 0));
            else if (k == 4) exp_q.push_back(mk(8'd0, 0, 1, 1, 0));
            else             exp_q.push_back(mk(8'd0, 0, 0, 1, 0));
            // A start during RUN (k == 2) must be ignored.
            tick(k == 0 || k == 2, (k == 0) ? 8'd4 : 8'd9, 1'b0, 1'b0, 1'b0);
            exp = exp_q.pop_front(); got = sample(); n_tests++;
            if (got !== exp) begin
                n_failed++;
                $display("FAIL oneshot[%0d]: got %s, expected %s", k, fmt(got), fmt(exp));
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_auto();
        obs_t got, exp;
        tick(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            if (k == 0)       exp_q.push_back(mk(8'd3, 1, 0, 0, 0));
            else if (k == 11) exp_q.push_back(mk(8'd0, 0, 0, 0, 0));
            else              exp_q.push_back(mk(8'(3 - (k % 3)), 1, (k % 3) == 0, 0, 0));
            tick(k == 0, 8'd3, 1'b1, 1'b0, k == 11);
            exp = exp_q.pop_front(); got = sample(); n_tests++;
            if (got !== exp) begin
                n_failed++;
                $display("FAIL auto[%0d]: got %s, expected %s", k, fmt(got), fmt(exp));
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_pause();
        obs_t got, exp;
        logic [7:0] exp_count [8] = '{8'd4, 8'd3, 8'd2, 8'd2, 8'd2, 8'd1, 8'd0, 8'd0};
        // Pause two cycles at count = 2: tc slips from t+4 to t+6.
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(mk(exp_count[k], k < 6, k == 6, k >= 6, 0));
            tick(k == 0, 8'd4, 1'b0, k == 3 || k == 4, 1'b0);
            exp = exp_q.pop_front(); got = sample(); n_tests++;
            if (got !== exp) begin
                n_failed++;
                $display("FAIL pause[%0d]: got %s, expected %s", k, fmt(got), fmt(exp));
            end
        end
        // Pause on the count = 1 edge suppresses tc for that edge.
        tick(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k == 0)      exp_q.push_back(mk(8'd2, 1, 0, 0, 0));
            else if (k < 3)  exp_q.push_back(mk(8'd1, 1, 0, 0, 0));
            else             exp_q.push_back(mk(8'd0, 0, 1, 1, 0));
            tick(k == 0, 8'd2, 1'b0, k == 2, 1'b0);
            exp = exp_q.pop_front(); got = sample(); n_tests++;
            if (got !== exp) begin
                n_failed++;
                $display("FAIL pause_at_one[%0d]: got %s, expected %s", k, fmt(got), fmt(exp));
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_err_and_full();
        obs_t got, exp;
        logic       s, a;
        logic [7:0] lv;
        tick(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 261; k++) begin
            s = 1'b0; a = 1'b0; lv = 8'd0;
            if (k == 0) begin
                s = 1'b1; exp_q.push_back(mk(8'd0, 0, 0, 0, 1));
            end else if (k == 1) begin
                exp_q.push_back(mk(8'd0, 0, 0, 0, 0));
            end else if (k == 2) begin
                s = 1'b1; a = 1'b1; lv = 8'd5;      // start+abort in IDLE: nothing
                exp_q.push_back(mk(8'd0, 0, 0, 0, 0));
            end else if (k == 3) begin
                s = 1'b1; lv = 8'd255;
                exp_q.push_back(mk(8'd255, 1, 0, 0, 0));
            end else if (k < 258) begin
                exp_q.push_back(mk(8'(258 - k), 1, 0, 0, 0));
            end else if (k == 258) begin
                exp_q.push_back(mk(8'd0, 0, 1, 1, 0));
            end else if (k == 259) begin
                s = 1'b1;                           // zero load from DONE
                exp_q.push_back(mk(8'd0, 0, 0, 1, 1));
            end else begin
                exp_q.push_back(mk(8'd0, 0, 0, 1, 0));
            end
            tick(s, lv, 1'b0, 1'b0, a);
            exp = exp_q.pop_front(); got = sample(); n_tests++;
            if (got !== exp) begin
                n_failed++;
                $display("FAIL err_full[%0d]: got %s, expected %s", k, fmt(got), fmt(exp));
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_abort_and_restart();
        obs_t got, exp;
        logic       s;
        logic [7:0] lv;
        tick(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 11; k++) begin
            s = 1'b0; lv = 8'd0;
            case (k)
                0:  begin s = 1'b1; lv = 8'd3; exp_q.push_back(mk(8'd3, 1, 0, 0, 0)); end
                1:  exp_q.push_back(mk(8'd2, 1, 0, 0, 0));
                2:  exp_q.push_back(mk(8'd1, 1, 0, 0, 0));
                3:  exp_q.push_back(mk(8'd0, 0, 0, 0, 0));   // abort at count = 1
                4:  exp_q.push_back(mk(8'd0, 0, 0, 0, 0));
                5:  begin s = 1'b1; lv = 8'd1; exp_q.push_back(mk(8'd1, 1, 0, 0, 0)); end
                6:  exp_q.push_back(mk(8'd0, 0, 1, 1, 0));
                7:  begin s = 1'b1; lv = 8'd2; exp_q.push_back(mk(8'd2, 1, 0, 0, 0)); end
                8:  exp_q.push_back(mk(8'd1, 1, 0, 0, 0));
                9:  exp_q.push_back(mk(8'd0, 0, 1, 1, 0));
                default: exp_q.push_back(mk(8'd0, 0, 0, 1, 0));
            endcase
            tick(s, lv, 1'b0, 1'b0, k == 3);
            exp = exp_q.pop_front(); got = sample(); n_tests++;
            if (got !== exp) begin
                n_failed++;
                $display("FAIL abort_restart[%0d]: got %s, expected %s", k, fmt(got), fmt(exp));
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_auto_one();
        obs_t got, exp;
        tick(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      exp_q.push_back(mk(8'd1, 1, 0, 0, 0));
            else if (k == 5) exp_q.push_back(mk(8'd1, 1, 0, 0, 0));   // paused
            else if (k == 7) exp_q.push_back(mk(8'd0, 0, 0, 0, 0));   // aborted
            else             exp_q.push_back(mk(8'd1, 1, 1, 0, 0));
            tick(k == 0, 8'd1, 1'b1, k == 5, k == 7);
            exp = exp_q.pop_front(); got = sample(); n_tests++;
            if (got !== exp) begin
                n_failed++;
                $display("FAIL auto_one[%0d]: got %s, expected %s", k, fmt(got), fmt(exp));
            end
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.load_val = 8'd0;
        bus.mode     = 1'b0;
        bus.pause    = 1'b0;
        bus.abort    = 1'b0;

        test_reset();
        test_oneshot();
        test_auto();
        test_pause();
        test_err_and_full();
        test_abort_and_restart();
        test_auto_one();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule : tb_countdown_unit
